// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_4
//  Purpose  : 4-way round-robin arbiter, registered one-hot grant, bounded tenure
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    state_t            state, state_next;
    logic [1:0]        ptr, ptr_next;
    logic [1:0]        idx_next;
    logic [1:0]        winner;
    logic [3:0]        gnt_next;
    logic              busy_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic              release_now;

    function automatic logic [3:0] decode(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Scan from lowest to highest priority so the highest-priority requester wins last.
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
            end
        end
    end

    assign release_now = !req[gnt_idx] || (hold_cnt >= HOLD_LIMIT);

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        idx_next   = gnt_idx;
        busy_next  = busy;
        ptr_next   = ptr;
        hold_next  = hold_cnt;
        case (state)
            IDLE: begin
                gnt_next  = 4'b0000;
                busy_next = 1'b0;
                if (En && (req != 4'b0000)) begin
                    state_next = GRANT;
                    idx_next   = winner;
                    gnt_next   = decode(winner);
                    busy_next  = 1'b1;
                    hold_next  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_next = IDLE;
                    gnt_next   = 4'b0000;
                    busy_next  = 1'b0;
                    ptr_next   = gnt_idx + 2'd1;
                    hold_next  = '0;
                end else if (hold_cnt < HOLD_LIMIT) begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
                busy_next  = 1'b0;
                hold_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            gnt_idx  <= 2'b00;
            busy     <= 1'b0;
            ptr      <= 2'b00;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            gnt_idx  <= idx_next;
            busy     <= busy_next;
            ptr      <= ptr_next;
            hold_cnt <= hold_next;
        end
    end

endmodule
`default_nettype wire
